// File: rtl/row_frame_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : row_frame_assembler_if
// Description : Host byte stream (valid/ready) plus row-data write port of
//               the LED panel row frame assembler.
// Revision    : 1.0 - initial release
// ============================================================================
interface row_frame_assembler_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [383:0] row_data;
  logic [3:0]   row_data_row_addr;
  logic [1:0]   row_data_panel_addr;
  logic         row_data_write_enable;

  // Host / controller side
  modport master (
    output in_data, in_valid,
    input  in_ready, row_data, row_data_row_addr, row_data_panel_addr,
           row_data_write_enable
  );

  // Assembler side
  modport slave (
    input  in_data, in_valid,
    output in_ready, row_data, row_data_row_addr, row_data_panel_addr,
           row_data_write_enable
  );
endinterface
`default_nettype wire

// File: rtl/row_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : row_frame_assembler
// Description : Frames a host byte stream into header + 48 data bytes +
//               XOR checksum, and commits each good 384-bit row to the
//               LED panel controller with a one-cycle write strobe.
//               Bad-checksum and stalled frames are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module row_frame_assembler #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  row_frame_assembler_if.slave bus,
  output logic                 busy,
  output logic [7:0]           frame_err_count
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]      LAST_IDX = 6'd47;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [47:0][7:0]  r_buf;
  logic [5:0]        r_idx;
  logic [7:0]        r_xor;
  logic [TMO_W-1:0]  r_tmo;
  logic [1:0]        r_panel;
  logic [3:0]        r_row;
  logic [383:0]      r_row_data;
  logic [3:0]        r_out_row;
  logic [1:0]        r_out_panel;
  logic              r_we;
  logic [7:0]        r_err_cnt;

  logic              w_ready;
  logic              w_accept;
  logic              w_header;
  logic              w_tmo_hit;
  logic              w_commit;
  logic              w_err;

  assign w_ready   = (r_state != ST_COMMIT);
  assign w_accept  = bus.in_valid & w_ready;
  assign w_header  = (bus.in_data[7:6] == 2'b10);
  assign w_tmo_hit = (r_tmo == TMO_LAST);
  assign w_commit  = (r_state == ST_COMMIT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and error-detect decode; an accepted byte always beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_header) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) w_state_nxt = ST_CHECK;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_err       = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_accept) begin
          if (bus.in_data == r_xor) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_err       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame capture: header addresses, shift buffer, byte index, running XOR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_idx   <= '0;
      r_xor   <= '0;
      r_panel <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_header) begin
            r_panel <= bus.in_data[5:4];
            r_row   <= bus.in_data[3:0];
            r_xor   <= bus.in_data;
            r_idx   <= '0;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_buf[r_idx] <= bus.in_data;
            r_xor        <= r_xor ^ bus.in_data;
            r_idx        <= r_idx + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter, live only while a frame is open
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_tmo <= '0;
    else if (r_state == ST_DATA || r_state == ST_CHECK)
      r_tmo <= w_accept ? '0 : r_tmo + TMO_W'(1);
    else                                           r_tmo <= '0;
  end

  // Output row registers and commit strobe, updated only on COMMIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_row_data  <= '0;
      r_out_row   <= '0;
      r_out_panel <= '0;
    end else begin
      r_we <= w_commit;
      if (w_commit) begin
        r_row_data  <= r_buf;
        r_out_row   <= r_row;
        r_out_panel <= r_panel;
      end
    end
  end

  // Saturating dropped-frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_err_cnt <= '0;
    else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.in_ready              = w_ready;
  assign bus.row_data              = r_row_data;
  assign bus.row_data_row_addr     = r_out_row;
  assign bus.row_data_panel_addr   = r_out_panel;
  assign bus.row_data_write_enable = r_we;
  assign busy                      = (r_state != ST_IDLE);
  assign frame_err_count           = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_row_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_frame_assembler
// Description : Self-checking bench for row_frame_assembler with a
//               frame-level reference model (byte queue, XOR over queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_frame_assembler;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [7:0] frame_err_count;

  always #5 clk = ~clk;

  row_frame_assembler_if bus ();

  row_frame_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus.slave),
    .busy            (busy),
    .frame_err_count (frame_err_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_we_cyc = -1000;
  int prev_we_cyc = -1000;

  // Reference model state
  bit           m_in_frame, m_stall, m_we;
  int           m_idle, m_err;
  logic [7:0]   m_frame [$];
  logic [383:0] m_row, p_row;
  logic [3:0]   m_raddr, p_raddr;
  logic [1:0]   m_paddr, p_paddr;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_stall = 0; m_we = 0; m_idle = 0; m_err = 0;
    m_frame.delete();
    m_row = '0; m_raddr = '0; m_paddr = '0;
  endtask

  task automatic err_inc();
    if (m_err < 255) m_err++;
  endtask

  // Frame-level behaviour for one rising edge
  task automatic model_edge(input bit v, input logic [7:0] d);
    logic [7:0] x;
    logic [7:0] h;
    bit xfer;
    xfer = v && !m_stall;
    m_we = 0;
    if (m_stall) begin
      m_stall = 0; m_we = 1;
      m_row = p_row; m_raddr = p_raddr; m_paddr = p_paddr;
    end else if (!m_in_frame) begin
      if (xfer && d[7:6] == 2'b10) begin
        m_in_frame = 1; m_frame.delete(); m_frame.push_back(d); m_idle = 0;
      end
    end else if (xfer) begin
      m_frame.push_back(d);
      m_idle = 0;
      if (m_frame.size() == 50) begin
        x = 8'h00;
        for (int i = 0; i < 49; i++) x ^= m_frame[i];
        if (x == d) begin
          m_stall = 1;
          h = m_frame[0];
          p_paddr = h[5:4];
          p_raddr = h[3:0];
          for (int k = 0; k < 48; k++) p_row[8*k +: 8] = m_frame[k+1];
        end else begin
          err_inc();
        end
        m_in_frame = 0;
        m_frame.delete();
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO) begin
        err_inc();
        m_in_frame = 0;
        m_frame.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", bus.in_ready, !m_stall);
    chk("busy", busy, m_in_frame || m_stall);
    chk("write_enable", bus.row_data_write_enable, m_we);
    chk("err_count", frame_err_count, m_err[7:0]);
    chk("row_data", bus.row_data, m_row);
    chk("row_addr", bus.row_data_row_addr, m_raddr);
    chk("panel_addr", bus.row_data_panel_addr, m_paddr);
    if (bus.row_data_write_enable === 1'b1) begin
      prev_we_cyc = last_we_cyc;
      last_we_cyc = cyc;
    end
  endtask

  // One clock: drive at negedge, model the edge, check at next negedge
  task automatic step(input bit v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gappy);
    bit done;
    bit v;
    bit rdy;
    done = 0;
    while (!done) begin
      v   = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = !m_stall;
      step(v, d);
      done = v && rdy;
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [383:0] pl,
                            input bit corrupt, input bit gappy,
                            input int pause_at, input int pause_len);
    logic [7:0] x;
    x = hdr;
    send_byte(hdr, gappy);
    for (int k = 0; k < 48; k++) begin
      x ^= pl[8*k +: 8];
      send_byte(pl[8*k +: 8], gappy);
      if (k == pause_at) repeat (pause_len) step(1'b0, 8'h00);
    end
    send_byte(x ^ {7'd0, corrupt}, gappy);
  endtask

  logic [383:0] ramp;
  logic [383:0] rnd;
  logic [7:0]   junk;
  int           err_before;

  initial begin
    for (int k = 0; k < 48; k++) ramp[8*k +: 8] = 8'(k);
    model_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset_n      = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 8'h00);

    // Good frame
    send_frame(8'hA5, ramp, 1'b0, 1'b0, -1, 0);
    chk("commit_not_yet", bus.row_data_write_enable, 1'b0);
    step(1'b0, 8'h00);
    chk("good_we", bus.row_data_write_enable, 1'b1);
    chk("good_panel", bus.row_data_panel_addr, 2'd2);
    chk("good_row", bus.row_data_row_addr, 4'd5);
    chk("good_byte0", bus.row_data[7:0], 8'h00);
    chk("good_byte47", bus.row_data[383:376], 8'h2F);
    chk("good_err", frame_err_count, 8'd0);
    step(1'b0, 8'h00);
    chk("strobe_one_cycle", bus.row_data_write_enable, 1'b0);

    // Bad checksum
    send_frame(8'hA5, ramp, 1'b1, 1'b0, -1, 0);
    step(1'b0, 8'h00);
    chk("bad_err", frame_err_count, 8'd1);
    chk("bad_busy", busy, 1'b0);
    chk("bad_byte47_kept", bus.row_data[383:376], 8'h2F);

    // Timeout after 10 data bytes
    send_byte(8'h9C, 1'b0);
    for (int k = 0; k < 10; k++) send_byte(8'(k + 100), 1'b0);
    repeat (TMO - 1) step(1'b0, 8'h00);
    chk("tmo_still_busy", busy, 1'b1);
    step(1'b0, 8'h00);
    chk("tmo_err", frame_err_count, 8'd2);
    chk("tmo_busy", busy, 1'b0);
    send_frame(8'hB3, ~ramp, 1'b0, 1'b0, -1, 0);
    step(1'b0, 8'h00);
    chk("after_tmo_we", bus.row_data_write_enable, 1'b1);
    chk("after_tmo_row", bus.row_data_row_addr, 4'd3);

    // Byte arriving exactly at the expiry cycle wins
    send_frame(8'h81, ramp ^ {48{8'h5A}}, 1'b0, 1'b0, 4, TMO - 1);
    step(1'b0, 8'h00);
    chk("boundary_we", bus.row_data_write_enable, 1'b1);
    chk("boundary_err", frame_err_count, 8'd2);

    // Junk in IDLE
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h7E, 1'b0);
    step(1'b0, 8'h00);
    chk("junk_err", frame_err_count, 8'd2);
    chk("junk_busy", busy, 1'b0);

    // Back-to-back with continuous valid
    send_frame(8'hA0, ramp, 1'b0, 1'b0, -1, 0);
    send_frame(8'hBF, ~ramp, 1'b0, 1'b0, -1, 0);
    step(1'b0, 8'h00);
    chk("b2b_gap", 32'(last_we_cyc - prev_we_cyc), 32'd51);

    // Randomised frames, junk, gaps and aborts
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 48; k++) rnd[8*k +: 8] = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        junk = 8'($urandom);
        if (junk[7:6] == 2'b10) junk[7] = 1'b0;
        send_byte(junk, 1'b1);
      end
      if (f % 9 == 8) begin
        send_byte({2'b10, 6'($urandom)}, 1'b1);
        repeat ($urandom_range(1, 20)) send_byte(8'($urandom), 1'b1);
        repeat (TMO + 1) step(1'b0, 8'h00);
      end else begin
        send_frame({2'b10, 6'($urandom)}, rnd, ($urandom_range(0, 3) == 0), 1'b1, -1, 0);
      end
    end
    step(1'b0, 8'h00);

    // Asynchronous reset mid-DATA
    send_byte(8'hAA, 1'b0);
    for (int k = 0; k < 10; k++) send_byte(8'(k), 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(8'hAE, rnd, 1'b0, 1'b0, -1, 0);
    step(1'b0, 8'h00);
    chk("post_reset_we", bus.row_data_write_enable, 1'b1);
    chk("post_reset_err", frame_err_count, 8'd0);

    // Saturation of the error counter
    err_before = m_err;
    for (int f = 0; f < 300; f++) send_frame(8'h80, ramp, 1'b1, 1'b0, -1, 0);
    step(1'b0, 8'h00);
    chk("sat_err", frame_err_count, 8'd255);
    chk("sat_start_zero", 32'(err_before), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
